// File: rtl/prv32_defines_pkg.sv
// Shared prv32 definitions: branch funct3 codes, EX/MEM stage FSM states,
// and the packed layout of the EX/MEM pipeline register.
package prv32_defines;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_KILL   = 1'b1
  } ex_mem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        trap_misalign;
  } mem_entry_t;

endpackage

// File: rtl/prv32_branch_cmp.sv
// Branch condition evaluator. Purely combinational.
// Inputs : funct3 (branch kind), ALU flags cf/zf/vf/sf from a SUB (cf=1 => a>=b unsigned).
// Output : taken.
module prv32_branch_cmp
  import prv32_defines::*;
(
  input  logic [2:0] funct3,
  input  logic       cf,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      BR_BEQ:  taken = zf;
      BR_BNE:  taken = ~zf;
      BR_BLT:  taken = (sf != vf);
      BR_BGE:  taken = (sf == vf);
      BR_BLTU: taken = ~cf;
      BR_BGEU: taken = cf;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/prv32_ex_mem_stage.sv
// EX-to-MEM boundary stage of the prv32 pipeline.
// Resolves branches/jumps into a registered one-cycle fetch redirect, picks the
// writeback value (ALU result or link address) and holds the instruction in a
// single-entry EX/MEM register with valid/ready handshakes on both sides.
// Ports:
//   ex_*      : EX-side instruction bundle and handshake (ex_valid/ex_ready)
//   alu_*     : ALU result and flags
//   redirect_*: fetch redirect pulse and target
//   mem_*     : registered EX/MEM fields and handshake (mem_valid/mem_ready)
//   flush     : pipeline kill, highest priority
module prv32_ex_mem_stage
  import prv32_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic            ex_reg_wr,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  input  logic            alu_zf,
  input  logic            alu_vf,
  input  logic            alu_sf,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_rs2,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_mem_rd,
  output logic            mem_mem_wr,
  output logic            mem_reg_wr,
  output logic            mem_trap_misalign
);

  ex_mem_state_e   state_q, state_d;
  logic            kill;

  logic            br_taken;
  logic            xfer_taken;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_addr;
  logic            misalign;
  logic            accept;
  logic            load;
  logic            redirect;

  mem_entry_t      entry_q, entry_d;
  logic            mem_valid_q, mem_valid_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  prv32_branch_cmp u_branch_cmp (
    .funct3 (ex_funct3),
    .cf     (alu_cf),
    .zf     (alu_zf),
    .vf     (alu_vf),
    .sf     (alu_sf),
    .taken  (br_taken)
  );

  // Control-transfer resolution
  always_comb begin
    xfer_taken = ex_jal | ex_jalr | (ex_branch & br_taken);
    rel_target = ex_pc + ex_imm;
    link_addr  = ex_pc + 32'd4;
    target     = ex_jalr ? {alu_r[XLEN-1:1], 1'b0} : rel_target;
    misalign   = xfer_taken & target[1];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  // FSM: next state. KILL always lasts one cycle; redirect already excludes
  // flush and wrong-path drops, so it alone decides entry into KILL.
  always_comb begin
    state_d = ST_NORMAL;
    if (state_q == ST_NORMAL && redirect) state_d = ST_KILL;
  end

  // FSM: outputs. In KILL the wrong-path instruction is swallowed, so no
  // downstream space is needed to accept it.
  always_comb begin
    kill     = (state_q == ST_KILL);
    ex_ready = ~mem_valid_q | mem_ready | kill;
  end

  always_comb begin
    accept   = ex_valid & ex_ready;
    load     = accept & ~kill & ~flush;
    redirect = load & xfer_taken & ~misalign;
  end

  // EX/MEM register next-state
  always_comb begin
    entry_d          = entry_q;
    mem_valid_d      = mem_valid_q;
    redirect_valid_d = redirect;
    redirect_pc_d    = redirect ? target : redirect_pc_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (load) begin
      mem_valid_d            = 1'b1;
      entry_d.pc             = ex_pc;
      entry_d.result         = (ex_jal | ex_jalr) ? link_addr : alu_r;
      entry_d.rs2            = ex_rs2;
      entry_d.rd             = ex_rd;
      entry_d.funct3         = ex_funct3;
      entry_d.mem_rd         = ex_mem_rd;
      entry_d.mem_wr         = ex_mem_wr;
      entry_d.reg_wr         = ex_reg_wr;
      entry_d.trap_misalign  = misalign;
    end else if (mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q          <= '0;
      mem_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      entry_q          <= entry_d;
      mem_valid_q      <= mem_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    mem_valid         = mem_valid_q;
    redirect_valid    = redirect_valid_q;
    redirect_pc       = redirect_pc_q;
    mem_pc            = entry_q.pc;
    mem_result        = entry_q.result;
    mem_rs2           = entry_q.rs2;
    mem_rd            = entry_q.rd;
    mem_funct3        = entry_q.funct3;
    mem_mem_rd        = entry_q.mem_rd;
    mem_mem_wr        = entry_q.mem_wr;
    mem_reg_wr        = entry_q.reg_wr;
    mem_trap_misalign = entry_q.trap_misalign;
  end

endmodule
